chanels_serializer: RTL

Transmit-side counterpart of the per-channel result distributor. Each of CHANELS compute units delivers one amplitude/phase pair per result, independently and possibly in the same cycle. The serializer parks each pair in a per-channel holding slot and emits them one per clock as a single time-multiplexed (valid, address, ac, ph) stream, using round-robin arbitration. The output stream drives the distributor's i_vld/i_addres/i_ac/i_ph directly; there is no back-pressure.

---
 rtl/chanels_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/chanels_serializer.sv | 82 ++++++++
 3 files changed

// File: rtl/chanels_pkg.sv
// rtl/chanels_pkg.sv - shared defaults and types for the channel serializer
package chanels_pkg;

    localparam int CHANELS = 4;
    localparam int WIDTH   = 32;
    localparam int ADDR_W  = $clog2(CHANELS);

    typedef struct packed {
        logic        [WIDTH-1:0] ac;
        logic signed [WIDTH-1:0] ph;
    } sample_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, scans upward from ptr with wrap
module rr_arbiter #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [AW-1:0] idx,
    output logic          any
);

    always_comb begin : scan
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j[AW-1:0];
            end
        end
    end

endmodule

// File: rtl/chanels_serializer.sv
// rtl/chanels_serializer.sv - parks per-channel ac/ph pairs and emits them one per clock, round-robin
module chanels_serializer #(
    parameter int CHANELS = chanels_pkg::CHANELS,
    parameter int WIDTH   = chanels_pkg::WIDTH,
    parameter int AW      = $clog2(CHANELS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANELS-1:0]         i_vld,
    input  logic [CHANELS*WIDTH-1:0]   i_ac,
    input  logic [CHANELS*WIDTH-1:0]   i_ph,
    input  logic                       i_clr_ovf,
    output logic                       o_vld,
    output logic [AW-1:0]              o_addres,
    output logic [WIDTH-1:0]           o_ac,
    output logic [WIDTH-1:0]           o_ph,
    output logic [CHANELS-1:0]         o_pend,
    output logic [CHANELS-1:0]         o_ovf
);

    logic [WIDTH-1:0]   ac_q [CHANELS];
    logic [WIDTH-1:0]   ph_q [CHANELS];
    logic [CHANELS-1:0] pend;
    logic [CHANELS-1:0] ovf;
    logic [CHANELS-1:0] ovf_set;
    logic [AW-1:0]      ptr;
    logic [CHANELS-1:0] gnt;
    logic [AW-1:0]      g_idx;
    logic               g_any;

    rr_arbiter #(.N(CHANELS), .AW(AW)) u_arb (
        .req (pend),
        .ptr (ptr),
        .gnt (gnt),
        .idx (g_idx),
        .any (g_any)
    );

    // A write into a slot that is being drained this cycle is a normal refill, not a loss.
    assign ovf_set = i_vld & pend & ~gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend     <= '0;
            ovf      <= '0;
            ptr      <= '0;
            o_vld    <= 1'b0;
            o_addres <= '0;
            o_ac     <= '0;
            o_ph     <= '0;
            for (int i = 0; i < CHANELS; i++) begin
                ac_q[i] <= '0;
                ph_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANELS; i++) begin
                if (i_vld[i]) begin
                    ac_q[i] <= i_ac[i*WIDTH +: WIDTH];
                    ph_q[i] <= i_ph[i*WIDTH +: WIDTH];
                end
            end
            pend <= i_vld | (pend & ~gnt);
            ovf  <= ovf_set | (i_clr_ovf ? '0 : ovf);
            if (g_any) begin
                o_vld    <= 1'b1;
                o_addres <= g_idx;
                o_ac     <= ac_q[g_idx];
                o_ph     <= ph_q[g_idx];
                ptr      <= (int'(g_idx) == CHANELS - 1) ? '0 : g_idx + AW'(1);
            end else begin
                o_vld    <= 1'b0;
                o_addres <= '0;
                o_ac     <= '0;
                o_ph     <= '0;
            end
        end
    end

    assign o_pend = pend;
    assign o_ovf  = ovf;

endmodule
